// File: rtl/devil_ace_master_port.sv
// ACE master port: turns one-hot attack-FSM phase flags into ACE channel handshakes.
// Latency: AR/AW valid one cycle after phase start; R/W/B feedback combinational; rack/wack one cycle.
// Backpressure: valids hold until the slave accepts; stalls count toward a sticky timeout flag.
module devil_ace_master_port #(
  parameter int C_ACE_DATA_WIDTH = 128,
  parameter int C_ACE_ADDR_WIDTH = 44,
  parameter int C_TIMEOUT_CYCLES = 1024
) (
  input  logic                          ace_aclk,
  input  logic                          ace_aresetn,
  input  logic [C_ACE_ADDR_WIDTH-1:0]   i_target_addr,
  input  logic                          i_ar_phase,
  input  logic                          i_r_phase,
  input  logic                          i_rack_phase,
  input  logic                          i_aw_phase,
  input  logic                          i_w_phase,
  input  logic                          i_b_phase,
  input  logic                          i_wack_phase,
  input  logic [C_ACE_DATA_WIDTH-1:0]   i_wdata,
  input  logic                          i_wlast,
  output logic                          o_arready,
  output logic                          o_rvalid,
  output logic                          o_rlast,
  output logic                          o_wready,
  output logic                          o_wvalid,
  output logic                          o_wlast,
  output logic                          o_bvalid,
  output logic                          o_bready,
  output logic                          o_rready,
  output logic [C_ACE_DATA_WIDTH-1:0]   o_rdata,
  output logic [1:0]                    o_bresp,
  output logic [C_ACE_ADDR_WIDTH-1:0]   m_araddr,
  output logic [C_ACE_ADDR_WIDTH-1:0]   m_awaddr,
  output logic                          m_arvalid,
  output logic                          m_awvalid,
  output logic                          m_wvalid,
  output logic                          m_wlast,
  output logic                          m_rready,
  output logic                          m_bready,
  output logic                          m_rack,
  output logic                          m_wack,
  input  logic                          m_arready,
  input  logic                          m_awready,
  input  logic                          m_wready,
  input  logic                          m_rvalid,
  input  logic                          m_rlast,
  input  logic                          m_bvalid,
  output logic [7:0]                    m_arlen,
  output logic [7:0]                    m_awlen,
  output logic [2:0]                    m_arsize,
  output logic [2:0]                    m_awsize,
  output logic [1:0]                    m_arburst,
  output logic [1:0]                    m_awburst,
  output logic [3:0]                    m_arsnoop,
  output logic [2:0]                    m_awsnoop,
  output logic [1:0]                    m_ardomain,
  output logic [1:0]                    m_awdomain,
  output logic [C_ACE_DATA_WIDTH-1:0]   m_wdata,
  output logic [C_ACE_DATA_WIDTH/8-1:0] m_wstrb,
  input  logic [C_ACE_DATA_WIDTH-1:0]   m_rdata,
  input  logic [3:0]                    m_rresp,
  input  logic [1:0]                    m_bresp,
  input  logic                          i_clear,
  output logic                          o_timeout,
  output logic                          o_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_VALID, ST_DONE} ch_st_t;

  localparam logic [15:0] LP_TMO_LAST = 16'(C_TIMEOUT_CYCLES - 1);

  ch_st_t                r_ar_st, w_ar_nxt, r_aw_st, w_aw_nxt;
  logic [C_ACE_ADDR_WIDTH-1:0] r_araddr, r_awaddr;
  logic [1:0]            r_rbeat, r_wbeat;
  logic [15:0]           r_tmo_cnt;
  logic                  r_rack_q, r_wack_q, r_rack, r_wack;
  logic                  r_err, r_timeout;
  logic                  w_rphase, w_wphase, w_bphase;
  logic                  w_ar_hs, w_aw_hs, w_r_hs, w_w_hs, w_b_hs, w_any_hs, w_any_phase, w_wait;
  logic                  w_r_err, w_w_err, w_b_err, w_flag_err, w_err_set, w_tmo_set;
  logic                  w_unused;

  // Combinational channel enables are forced low while reset is asserted so they drop at once.
  assign w_rphase = i_r_phase & ace_aresetn;
  assign w_wphase = i_w_phase & ace_aresetn;
  assign w_bphase = i_b_phase & ace_aresetn;

  assign m_arvalid = (r_ar_st == ST_VALID);
  assign m_awvalid = (r_aw_st == ST_VALID);
  assign m_araddr  = r_araddr;
  assign m_awaddr  = r_awaddr;
  assign w_ar_hs   = m_arvalid & m_arready;
  assign w_aw_hs   = m_awvalid & m_awready;
  assign o_arready = w_ar_hs;

  assign m_rready  = w_rphase;
  assign o_rready  = w_rphase;
  assign w_r_hs    = m_rvalid & w_rphase;
  assign o_rvalid  = w_r_hs;
  assign o_rdata   = m_rdata;
  assign o_rlast   = m_rlast & w_r_hs;

  assign m_wvalid  = w_wphase;
  assign m_wdata   = i_wdata;
  assign m_wlast   = i_wlast & w_wphase;
  assign m_wstrb   = '1;
  assign o_wvalid  = w_wphase;
  assign o_wready  = m_wready & w_wphase;
  assign o_wlast   = m_wlast;
  assign w_w_hs    = m_wready & w_wphase;

  assign m_bready  = w_bphase;
  assign o_bready  = w_bphase;
  assign w_b_hs    = m_bvalid & w_bphase;
  assign o_bvalid  = w_b_hs;
  assign o_bresp   = m_bresp;

  assign m_rack    = r_rack;
  assign m_wack    = r_wack;
  assign o_err     = r_err;
  assign o_timeout = r_timeout;

  // One 64-byte INCR burst of four 16-byte beats, ReadOnce / WriteUnique, inner shareable.
  assign m_arlen    = 8'd3;
  assign m_awlen    = 8'd3;
  assign m_arsize   = 3'd4;
  assign m_awsize   = 3'd4;
  assign m_arburst  = 2'b01;
  assign m_awburst  = 2'b01;
  assign m_arsnoop  = 4'b0000;
  assign m_awsnoop  = 3'b000;
  assign m_ardomain = 2'b01;
  assign m_awdomain = 2'b01;

  assign w_unused = &{1'b0, m_rresp[3:2], m_rresp[0], i_target_addr[5:0]};

  assign w_r_err    = w_r_hs & ((m_rlast != (r_rbeat == 2'd3)) | m_rresp[1]);
  assign w_w_err    = w_w_hs & (i_wlast != (r_wbeat == 2'd3));
  assign w_b_err    = w_b_hs & (m_bresp != 2'b00);
  assign w_flag_err = (i_ar_phase & i_aw_phase) | (i_r_phase & i_w_phase) |
                      (i_r_phase & i_b_phase) | (i_w_phase & i_b_phase);
  assign w_err_set  = w_r_err | w_w_err | w_b_err | w_flag_err;

  assign w_any_hs    = w_ar_hs | w_aw_hs | w_r_hs | w_w_hs | w_b_hs;
  assign w_any_phase = |{i_ar_phase, i_r_phase, i_rack_phase, i_aw_phase, i_w_phase, i_b_phase, i_wack_phase};
  assign w_wait      = (m_arvalid & ~m_arready) | (m_awvalid & ~m_awready) |
                       (w_rphase & ~m_rvalid) | (w_bphase & ~m_bvalid);
  assign w_tmo_set   = w_wait & ~w_any_hs & w_any_phase & (r_tmo_cnt >= LAST_OK(LP_TMO_LAST));

  function automatic logic [15:0] LAST_OK(input logic [15:0] v);
    return v;
  endfunction

  // AR/AW state registers.
  always_ff @(posedge ace_aclk or negedge ace_aresetn) begin
    if (!ace_aresetn) begin
      r_ar_st <= ST_IDLE;
      r_aw_st <= ST_IDLE;
    end else begin
      r_ar_st <= w_ar_nxt;
      r_aw_st <= w_aw_nxt;
    end
  end

  // AR next state: request on phase start, hold valid until accepted, wait for phase to end.
  always_comb begin
    w_ar_nxt = r_ar_st;
    case (r_ar_st)
      ST_IDLE:  if (i_ar_phase) w_ar_nxt = ST_VALID;
      ST_VALID: if (m_arready)  w_ar_nxt = ST_DONE;
      ST_DONE:  if (!i_ar_phase) w_ar_nxt = ST_IDLE;
      default:  w_ar_nxt = ST_IDLE;
    endcase
  end

  // AW next state: same as AR, but a concurrent AR request takes priority.
  always_comb begin
    w_aw_nxt = r_aw_st;
    case (r_aw_st)
      ST_IDLE:  if (i_aw_phase && !i_ar_phase) w_aw_nxt = ST_VALID;
      ST_VALID: if (m_awready)  w_aw_nxt = ST_DONE;
      ST_DONE:  if (!i_aw_phase) w_aw_nxt = ST_IDLE;
      default:  w_aw_nxt = ST_IDLE;
    endcase
  end

  // Capture the 64-byte-aligned target address when a request starts.
  always_ff @(posedge ace_aclk or negedge ace_aresetn) begin
    if (!ace_aresetn) begin
      r_araddr <= '0;
      r_awaddr <= '0;
    end else begin
      if (r_ar_st == ST_IDLE && i_ar_phase)
        r_araddr <= {i_target_addr[C_ACE_ADDR_WIDTH-1:6], 6'b0};
      if (r_aw_st == ST_IDLE && i_aw_phase && !i_ar_phase)
        r_awaddr <= {i_target_addr[C_ACE_ADDR_WIDTH-1:6], 6'b0};
    end
  end

  // Beat counters for R and W; both restart on the last beat.
  always_ff @(posedge ace_aclk or negedge ace_aresetn) begin
    if (!ace_aresetn) begin
      r_rbeat <= 2'd0;
      r_wbeat <= 2'd0;
    end else begin
      if (w_r_hs) r_rbeat <= m_rlast ? 2'd0 : r_rbeat + 2'd1;
      if (w_w_hs) r_wbeat <= i_wlast ? 2'd0 : r_wbeat + 2'd1;
    end
  end

  // Single-cycle RACK/WACK pulses on the rising edge of their phase flags.
  always_ff @(posedge ace_aclk or negedge ace_aresetn) begin
    if (!ace_aresetn) begin
      r_rack_q <= 1'b0;
      r_wack_q <= 1'b0;
      r_rack   <= 1'b0;
      r_wack   <= 1'b0;
    end else begin
      r_rack_q <= i_rack_phase;
      r_wack_q <= i_wack_phase;
      r_rack   <= i_rack_phase & ~r_rack_q;
      r_wack   <= i_wack_phase & ~r_wack_q;
    end
  end

  // Stall counter: restarts on any handshake or when the FSM is idle, saturates at all-ones.
  always_ff @(posedge ace_aclk or negedge ace_aresetn) begin
    if (!ace_aresetn)
      r_tmo_cnt <= 16'd0;
    else if (w_any_hs || !w_any_phase)
      r_tmo_cnt <= 16'd0;
    else if (w_wait && r_tmo_cnt != 16'hFFFF)
      r_tmo_cnt <= r_tmo_cnt + 16'd1;
  end

  // Sticky status; a new event in the clearing cycle keeps the flag set.
  always_ff @(posedge ace_aclk or negedge ace_aresetn) begin
    if (!ace_aresetn) begin
      r_err     <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if (w_err_set)    r_err <= 1'b1;
      else if (i_clear) r_err <= 1'b0;
      if (w_tmo_set)    r_timeout <= 1'b1;
      else if (i_clear) r_timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_devil_ace_master_port.sv
// Directed bench for devil_ace_master_port: read, write, error, stall, mid-burst reset, flag conflict.
// Inputs change 1ns after the rising edge; outputs are checked before the next edge.
// Every comparison goes through chk; summary reports passed/total.
module tb_devil_ace_master_port;
  localparam int DW = 128;
  localparam int AW = 44;

  logic ace_aclk = 1'b0;
  logic ace_aresetn;
  logic [AW-1:0] i_target_addr;
  logic i_ar_phase, i_r_phase, i_rack_phase, i_aw_phase, i_w_phase, i_b_phase, i_wack_phase;
  logic [DW-1:0] i_wdata;
  logic i_wlast;
  logic o_arready, o_rvalid, o_rlast, o_wready, o_wvalid, o_wlast, o_bvalid, o_bready, o_rready;
  logic [DW-1:0] o_rdata;
  logic [1:0] o_bresp;
  logic [AW-1:0] m_araddr, m_awaddr;
  logic m_arvalid, m_awvalid, m_wvalid, m_wlast, m_rready, m_bready, m_rack, m_wack;
  logic m_arready, m_awready, m_wready, m_rvalid, m_rlast, m_bvalid;
  logic [7:0] m_arlen, m_awlen;
  logic [2:0] m_arsize, m_awsize;
  logic [1:0] m_arburst, m_awburst;
  logic [3:0] m_arsnoop;
  logic [2:0] m_awsnoop;
  logic [1:0] m_ardomain, m_awdomain;
  logic [DW-1:0] m_wdata;
  logic [DW/8-1:0] m_wstrb;
  logic [DW-1:0] m_rdata;
  logic [3:0] m_rresp;
  logic [1:0] m_bresp;
  logic i_clear, o_timeout, o_err;

  int n_chk = 0;
  int n_pass = 0;

  devil_ace_master_port #(
    .C_ACE_DATA_WIDTH(DW), .C_ACE_ADDR_WIDTH(AW), .C_TIMEOUT_CYCLES(16)
  ) dut (
    .ace_aclk(ace_aclk), .ace_aresetn(ace_aresetn), .i_target_addr(i_target_addr),
    .i_ar_phase(i_ar_phase), .i_r_phase(i_r_phase), .i_rack_phase(i_rack_phase),
    .i_aw_phase(i_aw_phase), .i_w_phase(i_w_phase), .i_b_phase(i_b_phase),
    .i_wack_phase(i_wack_phase), .i_wdata(i_wdata), .i_wlast(i_wlast),
    .o_arready(o_arready), .o_rvalid(o_rvalid), .o_rlast(o_rlast), .o_wready(o_wready),
    .o_wvalid(o_wvalid), .o_wlast(o_wlast), .o_bvalid(o_bvalid), .o_bready(o_bready),
    .o_rready(o_rready), .o_rdata(o_rdata), .o_bresp(o_bresp),
    .m_araddr(m_araddr), .m_awaddr(m_awaddr), .m_arvalid(m_arvalid), .m_awvalid(m_awvalid),
    .m_wvalid(m_wvalid), .m_wlast(m_wlast), .m_rready(m_rready), .m_bready(m_bready),
    .m_rack(m_rack), .m_wack(m_wack), .m_arready(m_arready), .m_awready(m_awready),
    .m_wready(m_wready), .m_rvalid(m_rvalid), .m_rlast(m_rlast), .m_bvalid(m_bvalid),
    .m_arlen(m_arlen), .m_awlen(m_awlen), .m_arsize(m_arsize), .m_awsize(m_awsize),
    .m_arburst(m_arburst), .m_awburst(m_awburst), .m_arsnoop(m_arsnoop), .m_awsnoop(m_awsnoop),
    .m_ardomain(m_ardomain), .m_awdomain(m_awdomain), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_bresp(m_bresp),
    .i_clear(i_clear), .o_timeout(o_timeout), .o_err(o_err)
  );

  always #5 ace_aclk = ~ace_aclk;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge ace_aclk);
    #1;
  endtask

  task automatic idle_inputs();
    i_ar_phase = 0; i_r_phase = 0; i_rack_phase = 0; i_aw_phase = 0;
    i_w_phase = 0; i_b_phase = 0; i_wack_phase = 0; i_wlast = 0; i_wdata = '0;
    m_arready = 0; m_awready = 0; m_wready = 0; m_rvalid = 0; m_rlast = 0; m_bvalid = 0;
    m_rdata = '0; m_rresp = 4'd0; m_bresp = 2'd0; i_clear = 0;
  endtask

  // Four clean R beats, last flagged on the fourth.
  task automatic read_beats(input string tag);
    i_r_phase = 1;
    for (int b = 0; b < 4; b++) begin
      m_rvalid = 1; m_rlast = (b == 3); m_rdata = DW'(64'hD0D0_0000 + b);
      #1;
      chk({tag, "_rvalid"}, o_rvalid, 1'b1);
      chk({tag, "_rlast"}, o_rlast, (b == 3));
      chk({tag, "_rdata"}, o_rdata, DW'(64'hD0D0_0000 + b));
      tick();
    end
    m_rvalid = 0; m_rlast = 0; i_r_phase = 0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int beat;
    int cyc;
    ace_aresetn = 0;
    i_target_addr = '0;
    idle_inputs();
    #12;
    chk("rst_arvalid", m_arvalid, 1'b0);
    chk("rst_awvalid", m_awvalid, 1'b0);
    chk("rst_araddr", m_araddr, '0);
    chk("rst_err", o_err, 1'b0);
    chk("rst_tmo", o_timeout, 1'b0);
    chk("rst_rack", m_rack, 1'b0);
    chk("const_arlen", m_arlen, 8'd3);
    chk("const_awsize", m_awsize, 3'd4);
    chk("const_domain", m_ardomain, 2'b01);
    chk("const_wstrb", m_wstrb, 16'hFFFF);
    #5 ace_aresetn = 1;
    tick();

    // ADL read
    i_target_addr = 44'h012_3456_789A;
    i_ar_phase = 1;
    tick();
    chk("adl_arvalid", m_arvalid, 1'b1);
    chk("adl_araddr", m_araddr, 44'h012_3456_7880);
    chk("adl_arready_lo", o_arready, 1'b0);
    tick(); tick();
    chk("adl_arvalid_hold", m_arvalid, 1'b1);
    m_arready = 1; #1;
    chk("adl_arready_hs", o_arready, 1'b1);
    tick();
    m_arready = 0; #1;
    chk("adl_arvalid_drop", m_arvalid, 1'b0);
    chk("adl_arready_one", o_arready, 1'b0);
    i_ar_phase = 0;
    tick();
    read_beats("adl");
    chk("adl_err", o_err, 1'b0);
    i_rack_phase = 1; #1;
    chk("adl_rack_pre", m_rack, 1'b0);
    tick();
    chk("adl_rack_pulse", m_rack, 1'b1);
    tick();
    chk("adl_rack_end", m_rack, 1'b0);
    i_rack_phase = 0;
    tick();

    // ADT write
    i_target_addr = 44'hABC_DEF0_1277;
    i_aw_phase = 1; m_awready = 1;
    tick();
    chk("adt_awvalid", m_awvalid, 1'b1);
    chk("adt_awaddr", m_awaddr, 44'hABC_DEF0_1240);
    chk("adt_arvalid_quiet", m_arvalid, 1'b0);
    tick();
    chk("adt_awvalid_drop", m_awvalid, 1'b0);
    i_aw_phase = 0; m_awready = 0;
    tick();
    i_w_phase = 1;
    beat = 0; cyc = 0;
    while (beat < 4 && cyc < 20) begin
      m_wready = ((cyc % 2) == 0);
      i_wdata = DW'(64'hBEEF_0000 + beat);
      i_wlast = (beat == 3);
      #1;
      chk("adt_wvalid", m_wvalid, 1'b1);
      chk("adt_wlast", m_wlast, (beat == 3));
      chk("adt_wdata", m_wdata, DW'(64'hBEEF_0000 + beat));
      chk("adt_wready", o_wready, m_wready);
      if (m_wready) beat++;
      tick();
      cyc++;
    end
    chk("adt_w_beats", beat, 4);
    chk("adt_w_cycles", cyc, 7);
    i_w_phase = 0; m_wready = 0; i_wlast = 0; #1;
    chk("adt_wlast_off", m_wlast, 1'b0);
    i_b_phase = 1; m_bvalid = 1; m_bresp = 2'b00; #1;
    chk("adt_bvalid", o_bvalid, 1'b1);
    chk("adt_bready", m_bready, 1'b1);
    tick();
    i_b_phase = 0; m_bvalid = 0;
    i_wack_phase = 1;
    tick();
    chk("adt_wack_pulse", m_wack, 1'b1);
    tick();
    chk("adt_wack_end", m_wack, 1'b0);
    i_wack_phase = 0;
    chk("adt_err", o_err, 1'b0);
    tick();

    // R error: bad resp on beat 1, early last on beat 2, clear racing an error
    i_r_phase = 1;
    m_rvalid = 1; m_rlast = 0; m_rresp = 4'd0;
    tick();
    chk("rerr_beat0_ok", o_err, 1'b0);
    m_rresp = 4'b0010;
    tick();
    chk("rerr_resp", o_err, 1'b1);
    m_rresp = 4'd0; m_rvalid = 0;
    tick();
    chk("rerr_sticky", o_err, 1'b1);
    m_rvalid = 1; m_rlast = 1; i_clear = 1;
    tick();
    chk("rerr_clear_race", o_err, 1'b1);
    m_rvalid = 0; m_rlast = 0; i_r_phase = 0;
    tick();
    chk("rerr_clear_done", o_err, 1'b0);
    i_clear = 0;
    tick();

    // Stall until timeout, then late handshake
    chk("stall_tmo_pre", o_timeout, 1'b0);
    i_target_addr = 44'h000_0000_1000;
    i_ar_phase = 1;
    tick();
    for (int k = 0; k < 15; k++) tick();
    chk("stall_tmo_15", o_timeout, 1'b0);
    tick();
    chk("stall_tmo_16", o_timeout, 1'b1);
    chk("stall_arvalid", m_arvalid, 1'b1);
    tick(); tick(); tick();
    m_arready = 1; #1;
    chk("stall_arready", o_arready, 1'b1);
    tick();
    m_arready = 0; i_ar_phase = 0; #1;
    chk("stall_arvalid_drop", m_arvalid, 1'b0);
    chk("stall_tmo_sticky", o_timeout, 1'b1);
    i_clear = 1;
    tick();
    chk("stall_tmo_clear", o_timeout, 1'b0);
    i_clear = 0;
    tick();

    // Reset in the middle of a read burst
    i_target_addr = 44'h0AB_CDEF_0123;
    i_ar_phase = 1;
    tick();
    i_r_phase = 1;
    for (int b = 0; b < 2; b++) begin
      m_rvalid = 1; m_rlast = 0;
      tick();
    end
    m_rvalid = 1; #1;
    chk("mrst_err_pre", o_err, 1'b0);
    chk("mrst_rready_pre", m_rready, 1'b1);
    ace_aresetn = 0; #1;
    chk("mrst_rready", m_rready, 1'b0);
    chk("mrst_arvalid", m_arvalid, 1'b0);
    chk("mrst_rvalid_fsm", o_rvalid, 1'b0);
    idle_inputs();
    #2 ace_aresetn = 1;
    tick();
    i_target_addr = 44'h0AB_CDEF_0123;
    i_ar_phase = 1; m_arready = 1;
    tick();
    chk("mrst_re_araddr", m_araddr, 44'h0AB_CDEF_0100);
    tick();
    i_ar_phase = 0; m_arready = 0;
    read_beats("mrst");
    chk("mrst_err_post", o_err, 1'b0);
    tick();

    // AR and AW requested together
    i_target_addr = 44'h000_0000_2040;
    i_ar_phase = 1; i_aw_phase = 1;
    tick();
    chk("dual_arvalid", m_arvalid, 1'b1);
    chk("dual_awvalid", m_awvalid, 1'b0);
    chk("dual_err", o_err, 1'b1);
    m_arready = 1;
    tick();
    i_ar_phase = 0; i_aw_phase = 0; m_arready = 0;
    tick();
    chk("dual_awvalid_after", m_awvalid, 1'b0);
    i_clear = 1;
    tick();
    chk("dual_clear", o_err, 1'b0);
    i_clear = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/devil_ace_master_port.md
Name: devil_ace_master_port

Overview:
- Downstream of the active-path attack FSM: turns its one-hot phase flags (AR/R/RACK/AW/W/B/WACK) into ACE master channel handshakes toward the interconnect.
- Returns handshake-qualified ready/valid/data/last/resp back to the FSM.
- Reads (ADL) issue one 64-byte ReadOnce burst; writes (ADT) issue one 64-byte WriteUnique burst.
- Tracks stalls and protocol errors in sticky flags for the control/status registers.

Parameters:
C_ACE_DATA_WIDTH, 128, R/W data width (one beat = 16 bytes)
C_ACE_ADDR_WIDTH, 44, address width
C_TIMEOUT_CYCLES, 1024, stall cycles before timeout flag (must be ≥2)

Ports:
ace_aclk  in  1  clock
ace_aresetn  in  1  asynchronous active-low reset
i_target_addr  in  C_ACE_ADDR_WIDTH  attack address, captured at phase start
i_ar_phase, i_r_phase, i_rack_phase, i_aw_phase, i_w_phase, i_b_phase, i_wack_phase  in  1 each  FSM phase flags
i_wdata  in  C_ACE_DATA_WIDTH  write beat from FSM
i_wlast  in  1  last write beat from FSM
o_arready, o_rvalid, o_rlast, o_wready, o_wvalid, o_wlast, o_bvalid, o_bready, o_rready  out  1 each  qualified feedback to FSM
o_rdata  out  C_ACE_DATA_WIDTH  read beat to FSM
o_bresp  out  2  write response to FSM
m_araddr / m_awaddr  out  C_ACE_ADDR_WIDTH  64B-aligned address
m_arvalid, m_awvalid, m_wvalid, m_wlast, m_rready, m_bready, m_rack, m_wack  out  1 each  ACE master signals
m_arready, m_awready, m_wready, m_rvalid, m_rlast, m_bvalid  in  1 each  ACE slave signals
m_arlen / m_awlen  out  8  constant 3
m_arsize / m_awsize  out  3  constant 4
m_arburst / m_awburst  out  2  constant 01 (INCR)
m_arsnoop  out  4  constant 0000 (ReadOnce)
m_awsnoop  out  3  constant 000 (WriteUnique)
m_ardomain / m_awdomain  out  2  constant 01 (inner shareable)
m_wdata  out  C_ACE_DATA_WIDTH;  m_wstrb  out  C_ACE_DATA_WIDTH/8  all ones
m_rdata  in  C_ACE_DATA_WIDTH;  m_rresp  in  4;  m_bresp  in  2
i_clear  in  1  clears sticky flags
o_timeout, o_err  out  1 each  sticky status

Behaviour:
- Reset (async assert, sync deassert): all m_*valid, m_rready, m_bready, m_rack, m_wack, o_* at 0; addresses 0; beat counter 0; flags 0.
- AR sub-FSM (IDLE/VALID/DONE):
  - IDLE with i_ar_phase: capture {i_target_addr[43:6], 6'b0} into m_araddr; next cycle m_arvalid=1.
  - m_arvalid holds until m_arready; it drops the cycle after the handshake.
  - o_arready = m_arvalid & m_arready, one cycle.
  - DONE waits for i_ar_phase low, then returns to IDLE.
- AW sub-FSM: identical to AR, using i_aw_phase, m_awaddr and m_awvalid.
- R channel:
  - m_rready = i_r_phase (combinational).
  - o_rvalid = m_rvalid & i_r_phase; o_rdata = m_rdata; o_rlast = m_rlast & o_rvalid.
  - 2-bit beat counter increments per handshake and clears on the last beat.
  - m_rlast on a beat other than 3, a missing rlast at beat 3, or m_rresp[1]=1 sets o_err.
- m_rack: registered copy of i_rack_phase rising edge; exactly one cycle.
- W channel:
  - m_wvalid = i_w_phase; m_wdata = i_wdata; m_wlast = i_wlast & i_w_phase.
  - o_wready = m_wready & i_w_phase; o_wvalid = m_wvalid.
  - Beat counter checks wlast on beat 3 only; a mismatch sets o_err.
- B channel:
  - m_bready = i_b_phase; o_bready = m_bready; o_bvalid = m_bvalid & i_b_phase; o_bresp = m_bresp.
  - A handshake with bresp≠00 sets o_err.
- m_wack: one-cycle registered pulse on i_wack_phase rising edge.
- Timeout:
  - A 16-bit counter increments while any of AR-VALID, AW-VALID, R or B waits without a handshake.
  - It resets on any handshake or when no phase flag is set.
  - Reaching C_TIMEOUT_CYCLES sets o_timeout (sticky); valids stay asserted, because ACE forbids withdrawing them.
- Simultaneous flags:
  - i_ar_phase and i_aw_phase together: AR is served, AW is ignored, o_err is set.
  - More than one flag from {R, W, B} together sets o_err.
- i_clear clears o_err/o_timeout; a new error in the same cycle wins.
- Reset mid-burst: all valids drop immediately and counters clear. This is permitted only under system-wide reset.

Test Plan:
- ADL read: i_target_addr=0x1234_5678_9A, AR phase, m_arready after 3 cycles, then 4 R beats with rlast on beat 3 → m_araddr=0x1234_5678_80, one-cycle o_arready, 4 o_rvalid pulses, o_rlast on beat 4, m_rack high exactly 1 cycle after i_rack_phase, o_err=0.
- ADT write: AW with m_awready immediate, W phase with m_wready toggling 1/0, B with bresp=00 → 4 W handshakes, m_wlast only on the 4th, m_wack 1-cycle pulse, o_err=0.
- R error: m_rlast on beat 2 and rresp=0010 on beat 1 → o_err=1 until i_clear; i_clear with a simultaneous error keeps o_err=1.
- Stall: m_arready held 0 for C_TIMEOUT_CYCLES=16 → o_timeout=1 at cycle 16, m_arvalid stays 1; handshake at cycle 20 → o_arready pulses.
- Reset mid-R: assert ace_aresetn=0 at beat 2 → m_rready, m_arvalid and the counters go to 0 asynchronously; after release, the next read runs normally.
- i_ar_phase and i_aw_phase both high → only m_arvalid asserts, o_err=1.
